// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the fetch/decode latch.
// Owns the PC, issues word reads to the icache and applies redirect,
// freeze and halt. One instruction per cycle is offered on valid_o,
// combinationally from ihit/iload while running.
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer so
// freeze never blocks the icache (adds the HOLD state).
//
// Ports:
//   CLK, nRST         clock, asynchronous active-low reset
//   freeze            hazard unit stalls the fetch/decode latch
//   redirect          taken branch/jump resolved downstream
//   redirect_pc       redirect target (word aligned)
//   halt              halt detected downstream, stop fetching permanently
//   iREN, iaddr       icache read request and word address
//   ihit, iload       icache data valid and read data
//   valid_o           instruction offered to the latch (latch enable)
//   instr_o           fetched instruction
//   curr_pc_o, npc_o  address of instr_o and that address + 4
//   halted_o          fetch permanently stopped
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        freeze,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] npc_o,
    output logic [31:0] curr_pc_o,
    output logic        halted_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

`ifdef FETCH_SKID_EN
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd3
    } state_t;
`endif

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   pend_pc, pend_pc_n;
    logic              halt_pend, halt_pend_n;

    // Instruction currently offered to the latch, before idle zeroing
    logic              offer_valid;
    logic [XLEN-1:0]   offer_instr;
    logic [XLEN-1:0]   offer_pc;

`ifdef FETCH_SKID_EN
    logic [XLEN-1:0]   buf_instr, buf_instr_n;
    logic [XLEN-1:0]   buf_pc, buf_pc_n;
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            pc        <= PC_INIT;
            pend_pc   <= '0;
            halt_pend <= 1'b0;
`ifdef FETCH_SKID_EN
            buf_instr <= '0;
            buf_pc    <= '0;
`endif
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            halt_pend <= halt_pend_n;
`ifdef FETCH_SKID_EN
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
`endif
        end
    end

    // Next-state and offer logic; priority halt > redirect > freeze > normal
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        halt_pend_n = halt_pend;
        iREN        = 1'b0;
        offer_valid = 1'b0;
        offer_instr = '0;
        offer_pc    = '0;
`ifdef FETCH_SKID_EN
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
`endif

        case (state)
            RUN: begin
`ifdef FETCH_SKID_EN
                iREN = 1'b1;
`else
                iREN = !freeze;
`endif
                if (halt) begin
                    if (ihit) begin
                        state_n = HALTED;
                    end else begin
                        // Let the outstanding read finish before stopping
                        halt_pend_n = 1'b1;
                        pend_pc_n   = pc;
                        state_n     = DRAIN;
                    end
                end else if (redirect) begin
                    if (ihit) begin
                        pc_n = redirect_pc;
                    end else begin
                        // iaddr must stay stable until the miss returns
                        pend_pc_n = redirect_pc;
                        state_n   = DRAIN;
                    end
                end else if (freeze) begin
`ifdef FETCH_SKID_EN
                    if (ihit) begin
                        offer_valid = 1'b1;
                        offer_instr = iload;
                        offer_pc    = pc;
                        buf_instr_n = iload;
                        buf_pc_n    = pc;
                        pc_n        = pc + WORD_STEP;
                        state_n     = HOLD;
                    end
`endif
                end else if (ihit) begin
                    offer_valid = 1'b1;
                    offer_instr = iload;
                    offer_pc    = pc;
                    pc_n        = pc + WORD_STEP;
                end
            end

            DRAIN: begin
                // Outstanding read must complete; its data is discarded
                iREN = 1'b1;
                if (halt) begin
                    halt_pend_n = 1'b1;
                end else if (redirect) begin
                    pend_pc_n = redirect_pc;
                end
                if (ihit) begin
                    pc_n    = (!halt && redirect) ? redirect_pc : pend_pc;
                    state_n = (halt_pend || halt) ? HALTED : RUN;
                end
            end

`ifdef FETCH_SKID_EN
            HOLD: begin
                offer_valid = 1'b1;
                offer_instr = buf_instr;
                offer_pc    = buf_pc;
                if (halt) begin
                    offer_valid = 1'b0;
                    state_n     = HALTED;
                end else if (redirect) begin
                    offer_valid = 1'b0;
                    pc_n        = redirect_pc;
                    state_n     = RUN;
                end else if (!freeze) begin
                    state_n = RUN;
                end
            end
`endif

            HALTED: begin
                state_n = HALTED;
            end

            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Idle outputs are driven to zero
    always_comb begin
        iaddr     = pc;
        halted_o  = (state == HALTED);
        valid_o   = offer_valid;
        instr_o   = offer_valid ? offer_instr : '0;
        curr_pc_o = offer_valid ? offer_pc : '0;
        npc_o     = offer_valid ? (offer_pc + WORD_STEP) : '0;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for each core's five-stage pipeline, sitting directly upstream of the fetch/decode latch. It owns the PC, issues word reads to the instruction cache, and applies branch/jump redirects. It also applies freeze back-pressure from the hazard unit and halt. It presents one fetched instruction per cycle (instr, npc, curr_pc, valid) to the latch, where valid drives the latch enable.

## Interface
- PC_INIT, 32'h0000_0000, reset PC (core 1 instantiated with 32'h0000_0200)
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- freeze  in  1  hazard unit stalling the fetch/decode latch; offered instruction not consumed
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  32  redirect target, word aligned
- halt  in  1  halt detected downstream; stop fetching permanently
- iREN  out  1  icache read request
- iaddr  out  32  icache word address
- ihit  in  1  icache data valid for iaddr this cycle
- iload  in  32  icache read data
- valid_o  out  1  instruction offered to latch (latch en)
- instr_o  out  32  fetched instruction
- npc_o  out  32  curr_pc_o + 4
- curr_pc_o  out  32  address of instr_o
- halted_o  out  1  fetch stopped

## Operation
- State: pc (32), state in {RUN, DRAIN, HOLD, HALTED}, pend_pc (32), halt_pend (1), buffer buf_instr/buf_pc (skid only).
- Reset: pc=PC_INIT, state=RUN, halt_pend=0, pend_pc=0, buffer cleared.
- Priority each cycle: halt > redirect > freeze > normal.
- **RUN:**
  - iREN=!freeze (skid disabled) or 1 (skid enabled); iaddr=pc.
  - Normal, ihit: valid_o=1, instr_o=iload, curr_pc_o=pc, pc<=pc+4.
  - Redirect with ihit: valid_o=0, pc<=redirect_pc, stay RUN.
  - Redirect without ihit: the request is outstanding, so iaddr must stay stable. pend_pc<=redirect_pc, go DRAIN.
  - Halt with ihit: go HALTED.
  - Halt without ihit: halt_pend<=1, go DRAIN with pend_pc<=pc.
- **DRAIN:**
  - iREN=1, iaddr=pc, valid_o=0.
  - A new redirect overwrites pend_pc.
  - Halt sets halt_pend.
  - On ihit, data is discarded and pc<=pend_pc. Next state is HALTED if halt_pend is set (or halt is asserted this cycle), otherwise RUN.
- **HOLD** (skid only):
  - iREN=0.
  - valid_o=1 with instr_o=buf_instr, curr_pc_o=buf_pc.
  - !freeze: consumed, go RUN.
  - Redirect: drop buffer, pc<=redirect_pc, RUN.
  - Halt: HALTED.
- **HALTED:** iREN=0, valid_o=0, halted_o=1. Sticky until nRST.
- npc_o is always curr_pc_o+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- When valid_o=0, instr_o/curr_pc_o/npc_o are don't-care but driven to 0.

## Timing
- Zero-cycle fetch-to-latch path: valid_o/instr_o are combinational from ihit/iload in RUN. They are registered by the latch on the same edge that advances pc.
- Cache hit: one instruction per cycle, with no bubbles.
- Miss: iREN and iaddr are held constant until ihit.
- Redirect: the target is requested the cycle after the redirect edge. The redirect cycle offers nothing.
- In DRAIN, the target is requested the cycle after ihit.
- Reset output values: iREN=1, iaddr=PC_INIT, valid_o=0 (ihit low), halted_o=0.
- nRST mid-miss or in DRAIN/HOLD returns immediately to RUN at PC_INIT; the pending redirect is lost.

## Configuration
- FETCH_SKID_EN defined: a one-entry skid buffer is used.
  - In RUN with ihit && freeze: buf_instr<=iload, buf_pc<=pc, pc<=pc+4, go HOLD.
  - The icache is never blocked by freeze.
- FETCH_SKID_EN undefined:
  - No buffer; the HOLD state is unreachable and removed.
  - iREN=0 whenever freeze is asserted in RUN, and pc holds.
  - Freeze does not affect DRAIN, because the outstanding miss must complete.

## Test plan
- Reset with PC_INIT=0x200, ihit=1, iload=0x0000_0020 every cycle → iaddr 0x200, 0x204, 0x208 on consecutive cycles; curr_pc_o/npc_o 0x200/0x204 first; valid_o=1 each cycle.
- Miss: ihit low 4 cycles at pc=0x10, then ihit → iaddr=0x10 stable 5 cycles, valid_o only in cycle 5, next iaddr 0x14.
- Redirect to 0x80 during miss at 0x10 (cycle 2), second redirect to 0x90 at cycle 3, ihit at cycle 5 → valid_o=0 at cycle 5; iaddr=0x90 at cycle 6.
- Freeze for 3 cycles with ihit=1, pc=0x40:
  - Skid on: one instruction buffered (curr_pc_o=0x40 held), then 0x44 fetched after release.
  - Skid off: iREN=0 for 3 cycles, pc stays 0x40.
- Halt and redirect in the same cycle with ihit → HALTED; halted_o=1, iREN=0, valid_o=0; state persists 10 cycles.
- nRST asserted in DRAIN with pend_pc=0x100 → after release, iaddr=PC_INIT and state RUN.
